// File: rtl/tea_pkg.sv
// Shared constants, FSM encoding and the TEA mixing function.
package tea_pkg;
  localparam logic [31:0] DELTA        = 32'h9E3779B9;
  localparam logic [31:0] SUM_DEC_INIT = 32'hC6EF3720;
  localparam int          NUM_ROUNDS   = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction
endpackage

// File: rtl/decrypt.sv
// Decrypt-only wrapper around the TEA core.
module decrypt #(
  parameter logic [127:0] KEY     = 128'h0,
  parameter logic [31:0]  V0_INIT = 32'h41EA3A0A,
  parameter logic [31:0]  V1_INIT = 32'h94BAA940
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [31:0] v0_out,
  output logic [31:0] v1_out,
  output logic [5:0]  bits
);
  tea_crypt #(.MODE(1), .KEY(KEY), .V0_INIT(V0_INIT), .V1_INIT(V1_INIT)) u_core (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .v0_out(v0_out), .v1_out(v1_out), .bits(bits)
  );
endmodule

// File: rtl/encrypt.sv
// Encrypt-only wrapper around the TEA core.
module encrypt #(
  parameter logic [127:0] KEY     = 128'h0,
  parameter logic [31:0]  V0_INIT = 32'h0,
  parameter logic [31:0]  V1_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [31:0] v0_out,
  output logic [31:0] v1_out,
  output logic [5:0]  bits
);
  tea_crypt #(.MODE(0), .KEY(KEY), .V0_INIT(V0_INIT), .V1_INIT(V1_INIT)) u_core (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .v0_out(v0_out), .v1_out(v1_out), .bits(bits)
  );
endmodule

// File: rtl/tea_round.sv
// One combinational TEA round; the two half-updates chain within the cycle.
module tea_round
  import tea_pkg::*;
(
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  input  logic         mode,
  output logic [31:0]  v0_nxt,
  output logic [31:0]  v1_nxt,
  output logic [31:0]  sum_nxt
);
  logic [31:0] k0, k1, k2, k3, s;

  assign k0 = key[127:96];
  assign k1 = key[95:64];
  assign k2 = key[63:32];
  assign k3 = key[31:0];

  always_comb begin
    s       = sum + DELTA;
    v0_nxt  = v0;
    v1_nxt  = v1;
    sum_nxt = sum;
    if (!mode) begin
      v0_nxt  = v0 + tea_f(v1, s, k0, k1);
      v1_nxt  = v1 + tea_f(v0_nxt, s, k2, k3);
      sum_nxt = s;
    end else begin
      // decrypt undoes the halves in reverse order, using the pre-decrement sum
      v1_nxt  = v1 - tea_f(v0, sum, k2, k3);
      v0_nxt  = v0 - tea_f(v1_nxt, sum, k0, k1);
      sum_nxt = sum - DELTA;
    end
  end
endmodule

// File: rtl/tea_crypt.sv
// TEA core: one round per clock over 32 rounds, constant key and input block.
module tea_crypt
  import tea_pkg::*;
#(
  parameter int           MODE    = 0,
  parameter logic [127:0] KEY     = 128'h0,
  parameter logic [31:0]  V0_INIT = (MODE != 0) ? 32'h41EA3A0A : 32'h0,
  parameter logic [31:0]  V1_INIT = (MODE != 0) ? 32'h94BAA940 : 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [31:0] v0_out,
  output logic [31:0] v1_out,
  output logic [5:0]  bits
);
  localparam logic [31:0] SUM_INIT = (MODE != 0) ? SUM_DEC_INIT : 32'h0;

  state_t      state;
  logic [31:0] sum;
  logic [31:0] v0_nxt, v1_nxt, sum_nxt;

  tea_round u_round (
    .v0      (v0_out),
    .v1      (v1_out),
    .sum     (sum),
    .key     (KEY),
    .mode    (MODE != 0),
    .v0_nxt  (v0_nxt),
    .v1_nxt  (v1_nxt),
    .sum_nxt (sum_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      v0_out <= '0;
      v1_out <= '0;
      sum    <= '0;
      bits   <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          v0_out <= V0_INIT;
          v1_out <= V1_INIT;
          sum    <= SUM_INIT;
          bits   <= '0;
          state  <= RUN;
        end
        RUN: begin
          v0_out <= v0_nxt;
          v1_out <= v1_nxt;
          sum    <= sum_nxt;
          bits   <= bits + 6'd1;
          if (bits == 6'(NUM_ROUNDS - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (!start) begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tea_crypt.sv
// Bench: four cores (enc/dec, zero and nonzero key) driven by a shared start/reset.
module tb_tea_crypt;
  localparam logic [127:0] KEY1 = 128'h0123456789ABCDEFFEDCBA9876543210;

  // reference TEA encryption, used to build the nonzero-key ciphertext
  function automatic logic [63:0] tea_model(input logic [127:0] k, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] y, z, s;
    y = a; z = b; s = 32'h0;
    for (int r = 0; r < 32; r++) begin
      s = s + 32'h9E3779B9;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  localparam logic [63:0] ENC1 = tea_model(KEY1, 32'hDEADBEEF, 32'hCAFEBABE);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [3:0]       done_o;
  logic [3:0][31:0] v0_o, v1_o;
  logic [3:0][5:0]  bits_o;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  encrypt u_enc0 (.clk(clk), .reset(reset), .start(start), .done(done_o[0]),
                  .v0_out(v0_o[0]), .v1_out(v1_o[0]), .bits(bits_o[0]));
  decrypt u_dec0 (.clk(clk), .reset(reset), .start(start), .done(done_o[1]),
                  .v0_out(v0_o[1]), .v1_out(v1_o[1]), .bits(bits_o[1]));
  tea_crypt #(.MODE(0), .KEY(KEY1), .V0_INIT(32'hDEADBEEF), .V1_INIT(32'hCAFEBABE)) u_enc1 (
    .clk(clk), .reset(reset), .start(start), .done(done_o[2]),
    .v0_out(v0_o[2]), .v1_out(v1_o[2]), .bits(bits_o[2]));
  tea_crypt #(.MODE(1), .KEY(KEY1), .V0_INIT(ENC1[63:32]), .V1_INIT(ENC1[31:0])) u_dec1 (
    .clk(clk), .reset(reset), .start(start), .done(done_o[3]),
    .v0_out(v0_o[3]), .v1_out(v1_o[3]), .bits(bits_o[3]));

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] v0;
    logic [31:0] v1;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_", tbl[i].name, "_v"}, {v0_o[tbl[i].idx], v1_o[tbl[i].idx]},
          {tbl[i].v0, tbl[i].v1});
      chk({tag, "_", tbl[i].name, "_done"}, 64'(done_o[tbl[i].idx]), 64'd1);
      chk({tag, "_", tbl[i].name, "_bits"}, 64'(bits_o[tbl[i].idx]), 64'd32);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_v"}, {v0_o[i], v1_o[i]}, 64'h0);
      chk({tag, "_done_bits"}, {57'h0, done_o[i], bits_o[i]}, 64'h0);
    end
  endtask

  // start sampled at the next posedge; then 33 negedge samples: bits 0..32
  task automatic run_and_check(input string tag);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      chk({tag, "_lat_bits"}, 64'(bits_o[0]), 64'(k));
      chk({tag, "_lat_done"}, 64'(done_o[0]), (k == 32) ? 64'd1 : 64'd0);
      if (k == 1)
        chk({tag, "_round1"}, {v0_o[0], v1_o[0]}, 64'h9E3779B9_DBE8D32F);
    end
    check_results(tag);
  endtask

  initial begin
    tbl[0] = '{"enc0", 0, 32'h41EA3A0A, 32'h94BAA940};
    tbl[1] = '{"dec0", 1, 32'h0, 32'h0};
    tbl[2] = '{"enc1", 2, ENC1[63:32], ENC1[31:0]};
    tbl[3] = '{"dec1", 3, 32'hDEADBEEF, 32'hCAFEBABE};

    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("idle");

    run_and_check("run1");

    // start held high in DONE: no rerun, everything holds
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_results("hold");
    end

    start = 1'b0;
    @(negedge clk);
    chk("idle_done", 64'(done_o[0]), 64'd0);
    chk("idle_keep", {v0_o[0], v1_o[0]}, 64'h41EA3A0A_94BAA940);
    chk("idle_bits", 64'(bits_o[3]), 64'd32);

    run_and_check("run2");

    // abort after 10 rounds with an asynchronous reset
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= 10; c++) @(negedge clk);
    chk("mid_bits", 64'(bits_o[0]), 64'd10);
    #2 reset = 1'b0;
    #1 check_zero("abort");
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_and_check("run3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
